// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: owns the PC, issues in-order imem reads and buffers returns toward ID.
// Optional same-cycle bypass of an rvalid word into an empty queue when IFQ_BYPASS_EN is defined.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        IF_valid,
  input  logic        ID_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;
  logic [TW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     tag_pc_q   [MAX_OUTST];

  logic [PW:0]     count;
  logic            empty, credit_ok, fire, redir, byp, push, pop;
  logic [31:0]     head_inst, head_pc, tag_head;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    credit_ok = ((int'(outst_q) + int'(count)) < DEPTH) && (int'(outst_q) < MAX_OUTST);
    redir     = redirect_valid && (state_q != BOOT);
    imem_req  = (state_q == RUN) && !redirect_valid && credit_ok;
    imem_addr = fetch_pc_q;
    fire      = imem_req && imem_gnt;
    head_inst = inst_mem_q[rd_ptr_q[PW-1:0]];
    head_pc   = pc_mem_q[rd_ptr_q[PW-1:0]];
    tag_head  = tag_pc_q[tag_rd_q];
`ifdef IFQ_BYPASS_EN
    byp       = empty && (drop_q == '0) && !redir && imem_rvalid && (state_q != BOOT);
`else
    byp       = 1'b0;
`endif
    IF_valid  = !empty || byp;
    inst      = !empty ? head_inst : (byp ? imem_rdata : 32'h0);
    pc        = !empty ? head_pc   : (byp ? tag_head   : 32'h0);
    snpc      = IF_valid ? pc + 32'd4 : 32'h0;

    // A bypassed word taken by ID this cycle never enters the FIFO
    push      = imem_rvalid && (drop_q == '0) && !redir && !(byp && ID_ready);
    pop       = !empty && ID_ready && !redir;

    outst_d   = outst_q + OW'(fire) - OW'(imem_rvalid);
    tag_wr_d  = fire ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d  = imem_rvalid ? tag_inc(tag_rd_q) : tag_rd_q;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fetch_pc_d = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    drop_d    = (imem_rvalid && (drop_q != '0)) ? drop_q - 1'b1 : drop_q;

    if (redir) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      case (state_q)
        BOOT:      state_q <= RUN;
        RUN,
        DRAIN:     state_q <= (drop_d != '0) ? DRAIN : RUN;
        default:   state_q <= BOOT;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q[PW-1:0]] <= imem_rdata;
      pc_mem_q[wr_ptr_q[PW-1:0]]   <= tag_head;
    end
    if (fire) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
  end

endmodule
